mux_arb_n: RTL and testbench

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_arb_n.sv | 121 ++++++++++++
 tb/tb_mux_arb_n.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_arb_n.sv
// N-input multiplexer/arbiter with a registered output stage.
// Mode 0 routes an explicit select; mode 1 arbitrates round-robin.
module mux_arb_n #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    sel_err
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_data;
    logic             sel_oor;

    assign load    = !out_valid_q || out_ready;
    assign sel_oor = (int'(sel) >= int'(NUM_IN));

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        if (!mode) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grant     = SEL_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            // First pass covers [rr_ptr, NUM_IN-1], second pass wraps to the lowest index.
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (!grant_vld && in_valid[i] && SEL_W'(i) >= rr_ptr_q) begin
                    grant     = SEL_W'(i);
                    grant_vld = 1'b1;
                end
            end
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (!grant_vld && in_valid[i]) begin
                    grant     = SEL_W'(i);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            in_ready[i] = !rst && load && grant_vld && (grant == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = !mode && sel_oor && load && (|in_valid);
        if (load) begin
            if (grant_vld) begin
                out_data_d  = grant_data;
                out_ch_d    = grant;
                out_valid_d = 1'b1;
                if (mode) begin
                    rr_ptr_d = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (WIDTH=16, NUM_IN=3) with hand-computed expectations.
module tb_mux_arb_n;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_ch;
    logic                    sel_err;

    int errors = 0;
    int checks = 0;

    mux_arb_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 3'b111; mode = 1'b1; sel = '0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_ch", 32'(out_ch), 0);
        check("rst_sel_err", 32'(sel_err), 0);
        check("rst_in_ready", 32'(in_ready), 0);

        // Explicit select of channel 1
        tick();
        rst = 1'b0; mode = 1'b0; sel = 2'd1; in_valid = 3'b010; set_ch(1, 16'hBEEF);
        #1;
        check("m0_in_ready", 32'(in_ready), 32'b010);
        tick();
        check("m0_out_data", 32'(out_data), 32'hBEEF);
        check("m0_out_ch", 32'(out_ch), 1);
        check("m0_out_valid", 32'(out_valid), 1);
        in_valid = 3'b000;
        tick();
        check("idle_out_valid", 32'(out_valid), 0);
        check("idle_hold_data", 32'(out_data), 32'hBEEF);

        // Backpressure
        sel = 2'd0; in_valid = 3'b001; set_ch(0, 16'h1234);
        tick();
        check("bp_load_data", 32'(out_data), 32'h1234);
        out_ready = 1'b0; set_ch(0, 16'h5678);
        #1;
        check("bp_in_ready", 32'(in_ready), 0);
        tick();
        sel = 2'd2; set_ch(2, 16'hDEAD);
        tick();
        check("bp_hold_data", 32'(out_data), 32'h1234);
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_hold_ch", 32'(out_ch), 0);
        sel = 2'd0; out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b001);
        tick();
        check("bp_new_data", 32'(out_data), 32'h5678);
        in_valid = 3'b000;
        tick();

        // Out-of-range select
        sel = 2'd3; in_valid = 3'b111;
        #1;
        check("oor_in_ready", 32'(in_ready), 0);
        tick();
        check("oor_sel_err", 32'(sel_err), 1);
        check("oor_out_valid", 32'(out_valid), 0);
        check("oor_hold_data", 32'(out_data), 32'h5678);
        in_valid = 3'b000;
        tick();
        check("oor_sel_err_pulse", 32'(sel_err), 0);

        // Asynchronous reset while holding a word
        sel = 2'd1; in_valid = 3'b010; set_ch(1, 16'hBEEF);
        tick();
        check("pre_rst_valid", 32'(out_valid), 1);
        out_ready = 1'b0; in_valid = 3'b000;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_data", 32'(out_data), 0);
        check("async_rst_valid", 32'(out_valid), 0);
        tick();
        rst = 1'b0;

        // Round-robin from reset
        mode = 1'b1; out_ready = 1'b1; in_valid = 3'b111;
        set_ch(0, 16'hA000); set_ch(1, 16'hA001); set_ch(2, 16'hA002);
        #1;
        check("rr_first_ready", 32'(in_ready), 32'b001);
        tick();
        check("rr_ch_0", 32'(out_ch), 0);
        check("rr_data_0", 32'(out_data), 32'hA000);
        tick();
        check("rr_ch_1", 32'(out_ch), 1);
        tick();
        check("rr_ch_2", 32'(out_ch), 2);
        check("rr_data_2", 32'(out_data), 32'hA002);
        tick();
        check("rr_ch_3", 32'(out_ch), 0);
        tick();
        check("rr_ch_4", 32'(out_ch), 1);

        // rr_ptr is now 2; only channel 0 valid forces a wrap
        in_valid = 3'b001;
        #1;
        check("wrap_ready", 32'(in_ready), 32'b001);
        tick();
        check("wrap_out_ch", 32'(out_ch), 0);
        in_valid = 3'b111;
        #1;
        check("rr_ptr_is_1", 32'(in_ready), 32'b010);
        mode = 1'b0; sel = 2'd2;
        #1;
        check("mode_switch_ready", 32'(in_ready), 32'b100);
        mode = 1'b1; in_valid = 3'b101;
        #1;
        check("rr_skip_ready", 32'(in_ready), 32'b100);
        tick();
        check("rr_skip_ch", 32'(out_ch), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
